dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder, the memory end of the CPU's load/store interface. It accepts one word-addressed load/store request at a time over a valid/ready handshake and commits it to an internal word array. It returns read data or a status after a programmable wait, also over valid/ready. It owns the load-link/store-conditional reservation on the memory side, so the core no longer tracks the link register itself.

Parameters:
BITS, 32, data/address width
WORDS, 256, number of words in the array
BASE_ADDR, 32'h0, first word address served; word addressing, consecutive words differ by 1
LATENCY, 2, wait cycles between acceptance and resp_valid assertion (0..15)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept
req_rw_  input  1  1 = read, 0 = write
req_addr  input  BITS  word address
req_wdata  input  BITS  write data
req_byte_en  input  4  bit i = 1 writes byte lane i
req_ll  input  1  load-link (valid with a read only)
req_sc  input  1  store-conditional (valid with a write only)
resp_valid  output  1  response present
resp_ready  input  1  requester takes response
resp_rdata  output  BITS  read data
resp_sc_ok  output  1  store-conditional succeeded
resp_err  output  1  address out of range or illegal request

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: down-counter loaded with LATENCY-1.
  - RESP: resp_valid = 1.
  - req_ready is combinational: 1 only in IDLE.
- Acceptance: occurs on the clock edge where req_valid & req_ready.
  - The array write and the read-data/status capture both happen on that same edge.
  - Next state is WAIT if LATENCY > 0, else RESP. Response therefore arrives LATENCY+1 cycles after acceptance.
- RESP: hold resp_rdata, resp_sc_ok and resp_err stable until resp_valid & resp_ready, then return to IDLE.
  - No back-to-back acceptance on the completing edge; at most one outstanding request.
- Range check: idx = req_addr - BASE_ADDR (BITS wide, unsigned).
  - Out of range if req_addr < BASE_ADDR or idx >= WORDS.
  - Out-of-range request: resp_err = 1, no write, resp_rdata = 0, sc_ok = 0.
- Illegal requests: req_ll & req_sc, req_ll with a write, or req_sc with a read give resp_err = 1 and no array or link change.
- Read: resp_rdata = full word, independent of byte_en.
- Write: only enabled lanes are updated; byte_en = 0 is a legal no-op write.
- Link reservation (link_addr, link_valid):
  - LL read: sets link_addr = req_addr, link_valid = 1. A later LL overwrites the reservation.
  - SC: if link_valid & req_addr == link_addr, write is performed and sc_ok = 1; otherwise no write and sc_ok = 0. link_valid is cleared in both cases.
  - Plain write to link_addr (any byte_en) clears link_valid.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_sc_ok 0, resp_err 0, link_valid 0, link_addr 0.
  - Array contents are not reset.
  - Reset mid-WAIT/RESP discards the response. A write already committed stays committed.
- The wait counter uses $clog2(LATENCY+1) bits; LATENCY = 0 must not create a zero-width counter.

Optional Feature:
DMEM_STATS_EN:
- Defined: adds outputs stat_reads, stat_writes and stat_sc_fail, each 16 bits, saturating at 16'hFFFF and reset to 0.
  - stat_reads and stat_writes increment on each accepted in-range read or write (a failed SC counts as a write attempt).
  - stat_sc_fail increments on each SC with sc_ok = 0.
- Undefined: these ports and counters do not exist; functionality is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - state enum dmem_state_t {IDLE, WAIT, RESP};
  - the LATENCY_MAX = 15 constant;
  - a request struct dmem_req_t (rw_, addr, wdata, byte_en, ll, sc).
- One sub-module, dmem_link_monitor, holds link_addr/link_valid. It takes the accept strobe plus the request fields and outputs sc_ok and clear decisions.
- The array and FSM stay in dmem_responder.

Test Plan:
- LATENCY=2: write 32'hDEADBEEF to addr 5 with byte_en 4'hF, then read addr 5 -> resp_valid 3 cycles after acceptance, rdata 32'hDEADBEEF, err 0.
- Write 32'h11223344 with byte_en 4'b0101 over 32'hFFFFFFFF -> read returns 32'hFF22FF44.
- LL read addr 8, SC write 32'h7 to addr 8 -> sc_ok 1, memory 7. Repeat SC -> sc_ok 0, memory unchanged.
- LL addr 8, plain write to addr 8, then SC addr 8 -> sc_ok 0. Also SC to addr 9 after LL addr 8 -> sc_ok 0.
- Read addr WORDS (256) and addr BASE_ADDR-1 with BASE_ADDR=16 -> err 1, rdata 0. Illegal request (req_ll=1 with write) -> err 1, no write.
- Hold resp_ready=0 for 5 cycles -> resp fields stable, req_ready 0. Assert rst during WAIT -> resp_valid stays 0 and req_ready is 1 after rst deasserts.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// State encoding, latency bound and the request bundle.
package dmem_pkg;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic        rw_;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        ll;
    logic        sc;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between core and memory.
// master = core side, slave = memory responder.
interface dmem_responder_if #(
  parameter int BITS = 32
);

  logic            req_valid;
  logic            req_ready;
  logic            req_rw_;
  logic [BITS-1:0] req_addr;
  logic [BITS-1:0] req_wdata;
  logic [3:0]      req_byte_en;
  logic            req_ll;
  logic            req_sc;
  logic            resp_valid;
  logic            resp_ready;
  logic [BITS-1:0] resp_rdata;
  logic            resp_sc_ok;
  logic            resp_err;

  modport master (
    output req_valid, req_rw_, req_addr,
    output req_wdata, req_byte_en,
    output req_ll, req_sc, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_sc_ok, resp_err
  );

  modport slave (
    input  req_valid, req_rw_, req_addr,
    input  req_wdata, req_byte_en,
    input  req_ll, req_sc, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_sc_ok, resp_err
  );

endinterface

// File: rtl/dmem_link_monitor.sv
// Load-link / store-conditional reservation held at the memory side.
// ok marks a legal, in-range request; only those touch the link.
module dmem_link_monitor #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept,
  input  logic            ok,
  input  logic            rw_,
  input  logic [BITS-1:0] addr,
  input  logic            ll,
  input  logic            sc,
  output logic            sc_ok
);

  logic [BITS-1:0] link_addr;
  logic            link_valid;
  logic            addr_eq;
  logic            link_set;
  logic            link_clr;

  assign addr_eq  = (addr == link_addr);
  assign sc_ok    = ok & sc & ~rw_ & link_valid & addr_eq;
  assign link_set = accept & ok & rw_ & ll;
  // any SC consumes the link; a plain store to the linked word breaks it
  assign link_clr = accept & ok & ~rw_ & (sc | addr_eq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_addr  <= '0;
      link_valid <= 1'b0;
    end else if (link_set) begin
      link_addr  <= addr;
      link_valid <= 1'b1;
    end else if (link_clr) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering one load/store at a time.
// Optional DMEM_STATS_EN adds saturating read/write/sc-fail counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int              BITS      = 32,
  parameter int              WORDS     = 256,
  parameter logic [BITS-1:0] BASE_ADDR = '0,
  parameter int              LATENCY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]      stat_reads,
  output logic [15:0]      stat_writes,
  output logic [15:0]      stat_sc_fail
`endif
);

  localparam int LAT = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam int AW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CW  = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LAT > 0) ? LAT - 1 : 0);

  dmem_state_t     state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [BITS-1:0] mem [WORDS];

  dmem_req_t       req;
  logic [BITS-1:0] idx;
  logic [AW-1:0]   widx;
  logic            in_range;
  logic            illegal;
  logic            err;
  logic            accept;
  logic            sc_ok;
  logic            wr_en;

  logic [BITS-1:0] rdata_q;
  logic            sc_ok_q;
  logic            err_q;

  assign req = '{
    rw_:     bus.req_rw_,
    addr:    bus.req_addr,
    wdata:   bus.req_wdata,
    byte_en: bus.req_byte_en,
    ll:      bus.req_ll,
    sc:      bus.req_sc
  };

  assign idx      = req.addr - BASE_ADDR;
  assign widx     = idx[AW-1:0];
  assign in_range = (req.addr >= BASE_ADDR) &&
                    (idx < BITS'(WORDS));
  assign illegal  = (req.ll & req.sc) |
                    (req.ll & ~req.rw_) |
                    (req.sc & req.rw_);
  assign err      = ~in_range | illegal;
  assign accept   = bus.req_valid & bus.req_ready;
  assign wr_en    = accept & ~err & ~req.rw_ &
                    (~req.sc | sc_ok);

  dmem_link_monitor #(.BITS(BITS)) u_link (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .ok     (~err),
    .rw_    (req.rw_),
    .addr   (req.addr),
    .ll     (req.ll),
    .sc     (req.sc),
    .sc_ok  (sc_ok)
  );

  // array contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (req.byte_en[i]) begin
          mem[widx][8*i +: 8] <= req.wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      sc_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (req.rw_ & ~err) ? mem[widx] : '0;
      sc_ok_q <= sc_ok;
      err_q   <= err;
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_sc_ok = sc_ok_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (LAT > 0) begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end else begin
            state_nx = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - 1'b1;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef DMEM_STATS_EN
  logic sc_fail;
  assign sc_fail = accept & ~err & req.sc & ~sc_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads   <= '0;
      stat_writes  <= '0;
      stat_sc_fail <= '0;
    end else begin
      if (accept & ~err & req.rw_ & (stat_reads != 16'hFFFF))
        stat_reads <= stat_reads + 16'd1;
      if (accept & ~err & ~req.rw_ & (stat_writes != 16'hFFFF))
        stat_writes <= stat_writes + 16'd1;
      if (sc_fail & (stat_sc_fail != 16'hFFFF))
        stat_sc_fail <= stat_sc_fail + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases plus random traffic
// checked every cycle against a transaction-level memory model.
module tb_dmem_responder;

  localparam int          BITS  = 32;
  localparam int          WORDS = 256;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'd16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.BITS(BITS)) bus ();

`ifdef DMEM_STATS_EN
  logic [15:0] s_rd, s_wr, s_scf;
`endif

  dmem_responder #(
    .BITS      (BITS),
    .WORDS     (WORDS),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_STATS_EN
    ,
    .stat_reads   (s_rd),
    .stat_writes  (s_wr),
    .stat_sc_fail (s_scf)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit go     = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out", name);
  endtask

  // transaction-level model: memory words, link, outstanding response
  logic [31:0] m_mem [WORDS];
  bit          m_busy  = 1'b0;
  int          m_cnt   = 0;
  bit          m_lv    = 1'b0;
  logic [31:0] m_la    = '0;
  logic [31:0] e_rdata = '0;
  bit          e_sc    = 1'b0;
  bit          e_err   = 1'b0;

  task automatic model_accept();
    logic [31:0] a, idx;
    bit inr, ill, er, ok;
    a   = bus.req_addr;
    idx = a - BASE;
    inr = (a >= BASE) && (idx < WORDS);
    ill = (bus.req_ll && bus.req_sc) ||
          (bus.req_ll && !bus.req_rw_) ||
          (bus.req_sc && bus.req_rw_);
    er  = !inr || ill;
    ok  = !er && bus.req_sc && m_lv && (a == m_la);
    e_err   = er;
    e_sc    = ok;
    e_rdata = (!er && bus.req_rw_) ? m_mem[idx[7:0]] : 32'h0;
    if (!er) begin
      if (bus.req_rw_) begin
        if (bus.req_ll) begin
          m_lv = 1'b1;
          m_la = a;
        end
      end else begin
        if (!bus.req_sc || ok)
          for (int i = 0; i < 4; i++)
            if (bus.req_byte_en[i])
              m_mem[idx[7:0]][8*i +: 8] = bus.req_wdata[8*i +: 8];
        if (bus.req_sc || a == m_la) m_lv = 1'b0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_lv   = 1'b0;
      m_la   = '0;
    end else if (!m_busy) begin
      if (bus.req_valid) begin
        model_accept();
        m_busy = 1'b1;
        m_cnt  = 1;
      end
    end else if (m_cnt >= LAT + 1) begin
      if (bus.resp_ready) m_busy = 1'b0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      bit ev;
      ev = m_busy && (m_cnt >= LAT + 1);
      chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
      chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
      if (ev) begin
        chk("resp_rdata", bus.resp_rdata, e_rdata);
        chk("resp_sc_ok", 32'(bus.resp_sc_ok), 32'(e_sc));
        chk("resp_err", 32'(bus.resp_err), 32'(e_err));
      end
    end
  end

  task automatic do_req(input bit rw, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit ll, input bit sc, input int hold,
                        output logic [31:0] rd, output bit ok,
                        output bit er, output int lat);
    int w;
    rd = '0; ok = 1'b0; er = 1'b0; lat = 0;
    @(negedge clk);
    bus.req_rw_     = rw;
    bus.req_addr    = addr;
    bus.req_wdata   = wd;
    bus.req_byte_en = be;
    bus.req_ll      = ll;
    bus.req_sc      = sc;
    bus.req_valid   = 1'b1;
    bus.resp_ready  = 1'b0;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      fail_now("accept");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) begin
      fail_now("response");
      return;
    end
    rd = bus.resp_rdata;
    ok = bus.resp_sc_ok;
    er = bus.resp_err;
    repeat (hold) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    bit ok, er;
    int lat, k;
    bus.req_valid   = 1'b0;
    bus.req_rw_     = 1'b1;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_byte_en = '0;
    bus.req_ll      = 1'b0;
    bus.req_sc      = 1'b0;
    bus.resp_ready  = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst resp_sc_ok", 32'(bus.resp_sc_ok), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);
    #2 rst = 1'b0;
    go = 1'b1;

    for (int i = 0; i < 16; i++)
      do_req(0, BASE + i, $urandom, 4'hF, 0, 0, 0, rd, ok, er, lat);

    do_req(0, BASE + 5, 32'hDEADBEEF, 4'hF, 0, 0, 0, rd, ok, er, lat);
    do_req(1, BASE + 5, 32'h0, 4'h0, 0, 0, 0, rd, ok, er, lat);
    chk("latency", 32'(lat), 32'd3);
    chk("read word", rd, 32'hDEADBEEF);
    chk("read err", 32'(er), 32'd0);

    do_req(0, BASE + 6, 32'hFFFFFFFF, 4'hF, 0, 0, 0, rd, ok, er, lat);
    do_req(0, BASE + 6, 32'h11223344, 4'b0101, 0, 0, 0, rd, ok, er, lat);
    do_req(1, BASE + 6, 32'h0, 4'h0, 0, 0, 0, rd, ok, er, lat);
    chk("byte lanes", rd, 32'hFF22FF44);

    do_req(1, BASE + 8, 32'h0, 4'h0, 1, 0, 0, rd, ok, er, lat);
    do_req(0, BASE + 8, 32'h7, 4'hF, 0, 1, 0, rd, ok, er, lat);
    chk("sc hit", 32'(ok), 32'd1);
    do_req(0, BASE + 8, 32'h9, 4'hF, 0, 1, 0, rd, ok, er, lat);
    chk("sc repeat", 32'(ok), 32'd0);
    do_req(1, BASE + 8, 32'h0, 4'h0, 0, 0, 0, rd, ok, er, lat);
    chk("sc mem", rd, 32'h7);

    do_req(1, BASE + 8, 32'h0, 4'h0, 1, 0, 0, rd, ok, er, lat);
    do_req(0, BASE + 8, 32'h55, 4'h0, 0, 0, 0, rd, ok, er, lat);
    do_req(0, BASE + 8, 32'h66, 4'hF, 0, 1, 0, rd, ok, er, lat);
    chk("sc after store", 32'(ok), 32'd0);
    do_req(1, BASE + 8, 32'h0, 4'h0, 1, 0, 0, rd, ok, er, lat);
    do_req(0, BASE + 9, 32'h66, 4'hF, 0, 1, 0, rd, ok, er, lat);
    chk("sc other addr", 32'(ok), 32'd0);

    do_req(1, BASE + WORDS, 32'h0, 4'h0, 0, 0, 0, rd, ok, er, lat);
    chk("oor high err", 32'(er), 32'd1);
    chk("oor high rdata", rd, 32'd0);
    do_req(1, BASE - 1, 32'h0, 4'h0, 0, 0, 0, rd, ok, er, lat);
    chk("oor low err", 32'(er), 32'd1);
    chk("oor low rdata", rd, 32'd0);
    do_req(0, BASE + 5, 32'hABCD, 4'hF, 1, 0, 0, rd, ok, er, lat);
    chk("illegal err", 32'(er), 32'd1);
    do_req(1, BASE + 5, 32'h0, 4'h0, 0, 0, 5, rd, ok, er, lat);
    chk("illegal no write", rd, 32'hDEADBEEF);

    @(negedge clk);
    bus.req_rw_     = 1'b0;
    bus.req_addr    = BASE + 10;
    bus.req_wdata   = 32'h0BADF00D;
    bus.req_byte_en = 4'hF;
    bus.req_ll      = 1'b0;
    bus.req_sc      = 1'b0;
    bus.req_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst wait resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post rst req_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("post rst resp_valid", 32'(bus.resp_valid), 32'd0);
    do_req(1, BASE + 10, 32'h0, 4'h0, 0, 0, 0, rd, ok, er, lat);
    chk("committed write", rd, 32'h0BADF00D);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      a = BASE + $urandom_range(0, 15);
      case (k)
        0, 1, 2, 3:
          do_req(1, a, 32'h0, 4'h0, 0, 0,
                 $urandom_range(0, 3), rd, ok, er, lat);
        4, 5, 6:
          do_req(0, a, $urandom, 4'($urandom),
                 0, 0, $urandom_range(0, 3), rd, ok, er, lat);
        7:
          do_req(1, BASE + $urandom_range(0, 3), 32'h0, 4'h0,
                 1, 0, $urandom_range(0, 3), rd, ok, er, lat);
        8:
          do_req(0, BASE + $urandom_range(0, 3), $urandom,
                 4'($urandom), 0, 1,
                 $urandom_range(0, 3), rd, ok, er, lat);
        default: begin
          case ($urandom_range(0, 4))
            0: a = BASE - 32'($urandom_range(1, 4));
            1: a = BASE + WORDS + 32'($urandom_range(0, 3));
            2: a = 32'hFFFFFFF0;
            default: a = a;
          endcase
          if (a >= BASE && a < BASE + WORDS)
            do_req($urandom_range(0, 1), a, $urandom, 4'hF,
                   1, 1, 0, rd, ok, er, lat);
          else
            do_req($urandom_range(0, 1), a, $urandom, 4'hF,
                   0, 0, 0, rd, ok, er, lat);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    go = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
